pipeline_hazard_ctrl: RTL and testbench

Central hazard and stall sequencer for the 5-stage RV32I core. It produces the bubble (hold) and flush (zero) signals for every pipeline segment register: IF/ID, ID/EX, EX/MEM, MEM/WB and the PC.
- Resolves load-use data hazards and control hazards.
- Sequences multi-cycle data-cache miss stalls with an FSM.
- Keeps stall/miss performance counters and a miss-timeout error flag.

---
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: bubble/flush sequencer for the 5-stage RV32I pipeline.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   reg1_src_ID/reg2_src_ID        source registers of the ID instruction
//   src1_used_ID/src2_used_ID      ID instruction actually reads rs1/rs2
//   reg_dest_EX, load_EX           destination and load flag of the EX instruction
//   br_EX, jalr_EX, jal_ID         control-transfer indications
//   dcache_miss, dcache_ready      data-cache miss level and data-return indication
//   bubbleX/flushX                 hold/zero controls for PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   stall_cnt, miss_cnt            wrapping performance counters
//   err_timeout                    sticky flag: a miss waited TIMEOUT cycles
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       reg1_src_ID,
    input  logic [4:0]       reg2_src_ID,
    input  logic             src1_used_ID,
    input  logic             src2_used_ID,
    input  logic [4:0]       reg_dest_EX,
    input  logic             load_EX,
    input  logic             br_EX,
    input  logic             jalr_EX,
    input  logic             jal_ID,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    output logic             bubbleF,
    output logic             flushF,
    output logic             bubbleD,
    output logic             flushD,
    output logic             bubbleE,
    output logic             flushE,
    output logic             bubbleM,
    output logic             flushM,
    output logic             bubbleW,
    output logic             flushW,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             err_timeout
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t state, state_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic mem_stall, ctrl_flush, load_use, miss_start, waiting;

    // a miss answered in the same cycle is a hit, so ready always cancels the stall
    assign mem_stall  = !dcache_ready && (state == MEM_WAIT || dcache_miss);
    assign miss_start = state == RUN && dcache_miss && !dcache_ready;
    assign waiting    = state == MEM_WAIT && !dcache_ready;
    assign ctrl_flush = br_EX || jalr_EX;
    assign load_use   = load_EX && reg_dest_EX != 5'd0 &&
                        ((src1_used_ID && reg1_src_ID == reg_dest_EX) ||
                         (src2_used_ID && reg2_src_ID == reg_dest_EX));
    assign wait_inc   = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + 1'b1;

    always_comb begin
        state_nx = state;
        if (miss_start)
            state_nx = MEM_WAIT;
        else if (state == MEM_WAIT && dcache_ready)
            state_nx = RUN;
    end

    always_comb begin
        bubbleF = 1'b0;
        flushF  = 1'b0;
        bubbleD = 1'b0;
        flushD  = 1'b0;
        bubbleE = 1'b0;
        flushE  = 1'b0;
        bubbleM = 1'b0;
        flushM  = 1'b0;
        bubbleW = 1'b0;
        flushW  = 1'b0;
        if (rst) begin
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else if (mem_stall) begin
            // freeze everything up to MEM; WB gets a bubble while MEM waits
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            bubbleE = 1'b1;
            bubbleM = 1'b1;
            flushW  = 1'b1;
        end else if (ctrl_flush) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (load_use) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
        end else if (jal_ID) begin
            flushD = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            miss_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nx;
            if (bubbleF)
                stall_cnt <= stall_cnt + 1'b1;
            if (miss_start) begin
                miss_cnt <= miss_cnt + 1'b1;
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_inc;
            end
            if (waiting && wait_inc == WAIT_MAX)
                err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] reg1_src_ID, reg2_src_ID, reg_dest_EX;
    logic src1_used_ID, src2_used_ID, load_EX, br_EX, jalr_EX, jal_ID;
    logic dcache_miss, dcache_ready;
    logic bubbleF, flushF, bubbleD, flushD, bubbleE, flushE;
    logic bubbleM, flushM, bubbleW, flushW, err_timeout;
    logic [CW-1:0] stall_cnt, miss_cnt;

    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .reg1_src_ID(reg1_src_ID), .reg2_src_ID(reg2_src_ID),
        .src1_used_ID(src1_used_ID), .src2_used_ID(src2_used_ID),
        .reg_dest_EX(reg_dest_EX), .load_EX(load_EX),
        .br_EX(br_EX), .jalr_EX(jalr_EX), .jal_ID(jal_ID),
        .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
        .bubbleF(bubbleF), .flushF(flushF), .bubbleD(bubbleD), .flushD(flushD),
        .bubbleE(bubbleE), .flushE(flushE), .bubbleM(bubbleM), .flushM(flushM),
        .bubbleW(bubbleW), .flushW(flushW),
        .stall_cnt(stall_cnt), .miss_cnt(miss_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: a cache miss is "outstanding" from the miss cycle until data returns
    bit in_wait;
    int waited;
    bit err_m;
    logic [CW-1:0] stall_m, miss_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // order: {bF,fF,bD,fD,bE,fE,bM,fM,bW,fW}
    function automatic logic [9:0] expect_ctl();
        bit lu;
        lu = load_EX && reg_dest_EX != 0 &&
             ((src1_used_ID && reg1_src_ID == reg_dest_EX) ||
              (src2_used_ID && reg2_src_ID == reg_dest_EX));
        if (rst)                                        return 10'b01_01_01_01_01;
        if (!dcache_ready && (in_wait || dcache_miss))  return 10'b10_10_10_10_01;
        if (br_EX || jalr_EX)                           return 10'b00_01_01_00_00;
        if (lu)                                         return 10'b10_10_01_00_00;
        if (jal_ID)                                     return 10'b00_01_00_00_00;
        return 10'b0;
    endfunction

    task automatic idle();
        reg1_src_ID = 0; reg2_src_ID = 0; reg_dest_EX = 0;
        src1_used_ID = 0; src2_used_ID = 0; load_EX = 0;
        br_EX = 0; jalr_EX = 0; jal_ID = 0;
        dcache_miss = 0; dcache_ready = 0; rst = 0;
    endtask

    task automatic model_reset();
        in_wait = 0; waited = 0; err_m = 0; stall_m = 0; miss_m = 0;
    endtask

    // inputs are set just after an edge; check mid-cycle, then advance the model on the edge
    task automatic step();
        logic [9:0] e;
        #4;
        e = expect_ctl();
        check("ctl", {22'd0, bubbleF, flushF, bubbleD, flushD, bubbleE, flushE,
                      bubbleM, flushM, bubbleW, flushW}, {22'd0, e});
        check("stall_cnt", {24'd0, stall_cnt}, {24'd0, stall_m});
        check("miss_cnt", {24'd0, miss_cnt}, {24'd0, miss_m});
        check("err_timeout", {31'd0, err_timeout}, {31'd0, err_m});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e[9]) stall_m++;
            if (!in_wait && dcache_miss && !dcache_ready) begin
                in_wait = 1; miss_m++; waited = 0;
            end else if (in_wait) begin
                if (dcache_ready) in_wait = 0;
                else begin
                    waited++;
                    if (waited >= TO) err_m = 1;
                end
            end
        end
        #1;
    endtask

    task automatic set_load_use();
        load_EX = 1; reg_dest_EX = 5; reg1_src_ID = 5; src1_used_ID = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        step();
        check("rst_flushF", {31'd0, flushF}, 32'd1);
        rst = 0;
        step();

        set_load_use();
        step();
        check("lu_bubbleF", {31'd0, bubbleF}, 32'd1);
        idle();
        step();
        check("lu_stall_cnt", {24'd0, stall_cnt}, 32'd1);

        set_load_use(); reg_dest_EX = 0; reg1_src_ID = 0;
        step();
        idle();

        set_load_use(); br_EX = 1;
        step();
        check("br_lu_bubbleF", {31'd0, bubbleF}, 32'd0);
        idle();
        step();

        dcache_miss = 1;
        repeat (4) step();
        dcache_ready = 1;
        step();
        check("miss_cnt_one", {24'd0, miss_cnt}, 32'd1);
        check("stall_cnt_five", {24'd0, stall_cnt}, 32'd5);
        idle();
        dcache_miss = 1; dcache_ready = 1;
        step();
        idle();
        step();
        check("hit_miss_cnt", {24'd0, miss_cnt}, 32'd1);

        dcache_miss = 1; br_EX = 1;
        repeat (3) step();
        dcache_ready = 1;
        step();
        idle();

        dcache_miss = 1;
        repeat (12) step();
        check("timeout_set", {31'd0, err_timeout}, 32'd1);
        rst = 1;
        step();
        rst = 0; dcache_miss = 0;
        step();
        check("timeout_clr", {31'd0, err_timeout}, 32'd0);

        dcache_miss = 1;
        repeat (3) step();
        rst = 1;
        repeat (2) step();
        idle();
        step();
        check("midstall_miss_cnt", {24'd0, miss_cnt}, 32'd0);

        repeat (3000) begin
            rst          = $urandom_range(0, 199) == 0;
            reg1_src_ID  = 5'($urandom_range(0, 3));
            reg2_src_ID  = 5'($urandom_range(0, 3));
            reg_dest_EX  = 5'($urandom_range(0, 3));
            src1_used_ID = 1'($urandom_range(0, 1));
            src2_used_ID = 1'($urandom_range(0, 1));
            load_EX      = 1'($urandom_range(0, 1));
            br_EX        = $urandom_range(0, 7) == 0;
            jalr_EX      = $urandom_range(0, 15) == 0;
            jal_ID       = $urandom_range(0, 7) == 0;
            dcache_miss  = $urandom_range(0, 3) == 0;
            dcache_ready = $urandom_range(0, 2) == 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
